// File: rtl/procesador_pipe.sv
// Two-stage (EX/WB) datapath: register file, function unit, shifter and bus muxes,
// with write-back forwarding, registered status tags and a memory-wait stall.
module procesador_pipe #(
  parameter int m = 8,
  parameter int R = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         cw_valid,
  output logic         cw_ready,
  input  logic [R-1:0] A_sel,
  input  logic [R-1:0] B_sel,
  input  logic [R-1:0] D_sel,
  input  logic [3:0]   G_sel,
  input  logic [1:0]   H_sel,
  input  logic         MB_sel,
  input  logic         MF_sel,
  input  logic         MD_sel,
  input  logic         Load_en,
  input  logic [m-1:0] Cons_IN,
  input  logic [m-1:0] Data_IN,
  input  logic         mem_ready,
  output logic [3:0]   Tags,
  output logic [m-1:0] Address_out,
  output logic [m-1:0] Data_out,
  output logic         wb_valid
);

  localparam int unsigned NREG = 2 ** R;

  logic [m-1:0] rf_q [NREG];

  logic         wb_valid_q;
  logic [R-1:0] wb_dsel_q;
  logic         wb_md_q;
  logic         wb_le_q;
  logic [m-1:0] wb_f_q;

  logic [3:0]   tags_q, tags_d;
  logic [m-1:0] addr_q, data_q;

  logic         stall, accept, fwd_en;
  logic [m-1:0] wb_val;
  logic [m-1:0] a_bus, b_reg, b_bus;

  logic [m-1:0] fu_y, fu_out, sh_out, f_d;
  logic [m:0]   fu_sum;
  logic         fu_cin, fu_c, fu_v;

  assign stall    = wb_valid_q && wb_md_q && !mem_ready;
  assign cw_ready = !stall;
  assign accept   = cw_valid && cw_ready;

  // WB result bypasses the register file so a dependent op in EX never sees a stale value
  assign wb_val = wb_md_q ? Data_IN : wb_f_q;
  assign fwd_en = wb_valid_q && wb_le_q;
  assign a_bus  = (fwd_en && (wb_dsel_q == A_sel)) ? wb_val : rf_q[A_sel];
  assign b_reg  = (fwd_en && (wb_dsel_q == B_sel)) ? wb_val : rf_q[B_sel];
  assign b_bus  = MB_sel ? Cons_IN : b_reg;

  // Arithmetic codes share one adder: A + Y + cin
  always_comb begin
    fu_y   = '0;
    fu_cin = 1'b0;
    case (G_sel[2:0])
      3'd1:    fu_cin = 1'b1;
      3'd2:    fu_y   = b_bus;
      3'd3:    begin fu_y = b_bus;  fu_cin = 1'b1; end
      3'd4:    fu_y   = ~b_bus;
      3'd5:    begin fu_y = ~b_bus; fu_cin = 1'b1; end
      3'd6:    fu_y   = '1;
      default: ;
    endcase
    fu_sum = {1'b0, a_bus} + {1'b0, fu_y} + {{m{1'b0}}, fu_cin};

    fu_out = a_bus;
    fu_c   = 1'b0;
    fu_v   = 1'b0;
    if (!G_sel[3]) begin
      fu_out = fu_sum[m-1:0];
      fu_c   = fu_sum[m];
      fu_v   = (a_bus[m-1] == fu_y[m-1]) && (fu_sum[m-1] != a_bus[m-1]);
    end else if (!G_sel[2]) begin
      case (G_sel[1:0])
        2'd0:    fu_out = a_bus & b_bus;
        2'd1:    fu_out = a_bus | b_bus;
        2'd2:    fu_out = a_bus ^ b_bus;
        default: fu_out = ~a_bus;
      endcase
    end
  end

  always_comb begin
    case (H_sel)
      2'd0:    sh_out = b_bus;
      2'd1:    sh_out = b_bus >> 1;
      2'd2:    sh_out = b_bus << 1;
      default: sh_out = '0;
    endcase
  end

  always_comb begin
    f_d    = MF_sel ? sh_out : fu_out;
    tags_d = {MF_sel ? 1'b0 : fu_v, MF_sel ? 1'b0 : fu_c, f_d[m-1], f_d == '0};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_dsel_q  <= '0;
      wb_md_q    <= 1'b0;
      wb_le_q    <= 1'b0;
      wb_f_q     <= '0;
      tags_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (accept) begin
      wb_valid_q <= 1'b1;
      wb_dsel_q  <= D_sel;
      wb_md_q    <= MD_sel;
      wb_le_q    <= Load_en;
      wb_f_q     <= f_d;
      tags_q     <= tags_d;
      addr_q     <= a_bus;
      data_q     <= b_bus;
    end else if (!stall) begin
      wb_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (fwd_en && !stall) begin
      rf_q[wb_dsel_q] <= wb_val;
    end
  end

  assign Tags        = tags_q;
  assign Address_out = addr_q;
  assign Data_out    = data_q;
  assign wb_valid    = wb_valid_q;

endmodule
